keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time.
- Reads the already-synchronized active-low row lines.
- Debounces both press and release of a detected key.
- Emits a 4-bit hex key code with a one-cycle valid pulse, exactly once per debounced press.
- Sits directly downstream of the row synchronizer; its key/key_valid output feeds the display/entry logic.

Parameters:
- SCAN_CYCLES, 4, cycles each column is driven before rows are sampled. Must be >= 3 to cover the 2-cycle synchronizer latency plus settle.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release.
- CNT_W, 16, width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rows  input  4  synchronized row lines, active-low; bit r = row r
- cols  output  4  column drive, active-low, exactly one bit low at all times; bit c = column c
- key  output  4  hex code of the last accepted key; held until the next acceptance
- key_valid  output  1  one-cycle pulse when key updates

Behaviour:
- Reset (reset=0, async): state=SCAN, col_idx=0, cols=4'b1110, key=4'h0, key_valid=0, all counters 0.
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- All outputs are registered.

State SCAN:
- cols = ~(4'b0001 << col_idx).
- Settle counter counts 0..SCAN_CYCLES-1; rows are sampled only on the last count.
- If rows == 4'hF: col_idx advances, wrapping 3 -> 0; cols updates the same cycle; settle counter clears.
- Else: capture col_idx and the lowest-numbered low row (priority r0 > r1 > r2 > r3), then go to DEBOUNCE with the column held.

State DEBOUNCE:
- Column held.
- Each cycle the captured row is low, the counter increments.
- If the captured row goes high: return to SCAN at the next column, no output.
- When the counter reaches DEBOUNCE_CYCLES-1 with the row still low:
  - key <= mapped code and key_valid=1 for exactly one cycle (the transition cycle);
  - go to HELD.

State HELD:
- Column held; counter cleared.
- Stay while the captured row is low.
- Captured row high -> RELEASE.

State RELEASE:
- Counter counts consecutive high cycles of the captured row.
- Captured row low again -> HELD, counter cleared, no new pulse.
- Count reaches DEBOUNCE_CYCLES-1 -> SCAN at the next column.

Boundary conditions:
- Additional keys pressed while in DEBOUNCE/HELD/RELEASE are ignored. Other rows in the held column are not monitored; other columns are not driven.
- key_valid never asserts twice for one held press.
- key_valid never asserts during or in the cycle after reset deassertion.
- Reset mid-operation immediately returns all outputs to their reset values; a pending pulse is discarded.
- Counter never wraps; it saturates at the terminal count and the state leaves that cycle.

Decomposition:
- keypad_pkg holds:
  - typedef enum logic [1:0] state_t {SCAN, DEBOUNCE, HELD, RELEASE};
  - the 16-entry key-map constant array indexed {row,col};
  - the active-low "no row" constant 4'hF.
- One sub-module: keypad_decode, combinational {row_idx, col_idx} -> 4-bit code; used by keypad_scanner.
- Priority row encoding and counters stay in keypad_scanner.

Test Plan:
(bench: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8; keypad model drives raw rows through the existing 2-flop synchronizer)
- Reset then idle 32 cycles -> cols=1110 at reset; cols cycles 1110->1101->1011->0111->1110, changing every 4 cycles; key=0, key_valid never 1.
- Press '5' (row1, col1), hold 40 cycles -> exactly one key_valid pulse with key=4'h5; cols stays 1101 from detection until release is debounced.
- Press '9' (row2, col2) for 3 cycles then release -> no key_valid; scanning resumes at col3 (cols=0111).
- Hold 'A' (row0, col3), then 4-cycle release glitch, then full release of 10 cycles, then re-press -> one pulse for the glitch sequence, second pulse (key=4'hA) only after the re-press debounces.
- Press '1' (row0) and '7' (row2) together, both col0 -> single pulse, key=4'h1; pressing '3' while '1' held -> no pulse.
- Assert reset for 1 cycle mid-DEBOUNCE of 'D' -> cols=1110, key=0, key_valid=0 immediately; no pulse until a fresh press debounces.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t   - scanner FSM states
//   NO_ROW    - active-low row value meaning "no key on this column"
//   KEY_MAP   - hex code per key, indexed by {row, col}
//   col_drive - active-low column drive pattern for a column index
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [3:0] NO_ROW = 4'hF;

    // Row-major keypad legend: r0 = 1 2 3 A, r1 = 4 5 6 B,
    // r2 = 7 8 9 C, r3 = E 0 F D.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// keypad_decode: combinational key-position to hex-code lookup.
//   row_idx - row of the pressed key (0..3)
//   col_idx - column of the pressed key (0..3)
//   code    - 4-bit hex legend of that key
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] code
);

    assign code = KEY_MAP[{row_idx, col_idx}];

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time,
// debounces press and release of the detected key, and reports it once.
//   clk       - system clock
//   reset     - asynchronous, active-low reset
//   rows      - synchronized row lines, active-low, bit r = row r
//   cols      - column drive, active-low, exactly one bit low
//   key       - hex code of the last accepted key, held until the next one
//   key_valid - one-cycle pulse in the cycle key takes a new value
//   dbg_state - current FSM state, for observation only
//
// Output protocol: key_valid has no ready/backpressure. It is a single
// cycle strobe; the consumer must capture key in the cycle key_valid is 1.
// key stays stable afterwards, so late readers still see the last value.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output state_t     dbg_state
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q;
    logic [1:0]       col_q;
    logic [1:0]       row_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       cols_q;
    logic [3:0]       key_q;
    logic             valid_q;

    logic [1:0]       hit_row;
    logic             cap_low;
    logic [3:0]       code;

    // Lowest-numbered low row wins: scanning downwards lets row 0 overwrite.
    always_comb begin
        hit_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows[r]) hit_row = 2'(r);
        end
    end

    // Only the captured row of the held column is watched after detection.
    assign cap_low = ~rows[row_q];

    keypad_decode u_decode (
        .row_idx (row_q),
        .col_idx (col_q),
        .code    (code)
    );

    // One counter serves as settle counter in SCAN and as debounce counter
    // elsewhere; every state exit clears it, so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            cols_q  <= 4'b1110;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (rows == NO_ROW) begin
                            col_q  <= col_q + 2'd1;
                            cols_q <= col_drive(col_q + 2'd1);
                        end else begin
                            row_q   <= hit_row;
                            state_q <= DEBOUNCE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!cap_low) begin
                        // Bounce: abandon and move on without reporting.
                        cnt_q   <= '0;
                        col_q   <= col_q + 2'd1;
                        cols_q  <= col_drive(col_q + 2'd1);
                        state_q <= SCAN;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        key_q   <= code;
                        valid_q <= 1'b1;
                        state_q <= HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    cnt_q <= '0;
                    if (!cap_low) state_q <= RELEASE;
                end
                RELEASE: begin
                    if (cap_low) begin
                        // Release glitch: still the same press, no new pulse.
                        cnt_q   <= '0;
                        state_q <= HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        col_q   <= col_q + 2'd1;
                        cols_q  <= col_drive(col_q + 2'd1);
                        state_q <= SCAN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= SCAN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cols      = cols_q;
    assign key       = key_q;
    assign key_valid = valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a small keypad
// model (raw rows from pressed keys and driven columns) feeding a 2-flop
// row synchronizer, as in the real system.
module tb_keypad_scanner;
    import keypad_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    state_t     dbg_state;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .dbg_state (dbg_state)
    );

    // ---------------- keypad model + synchronizer ----------------
    logic [15:0] down = 16'h0;   // bit r*4+c = key at row r, col c pressed
    logic [3:0]  raw_rows;
    logic [3:0]  sync1 = 4'hF;
    logic [3:0]  sync2 = 4'hF;

    always_comb begin
        raw_rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (down[r*4+c] && !cols[c]) raw_rows[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        sync1 <= raw_rows;
        sync2 <= sync1;
    end
    assign rows = sync2;

    // ---------------- monitors ----------------
    int         pulses = 0;
    logic [3:0] pulse_key = 4'h0;
    int         bad_cols = 0;

    always @(posedge clk) begin
        if (key_valid === 1'b1) begin
            pulses    <= pulses + 1;
            pulse_key <= key;
        end
    end

    always @(negedge clk) begin
        if (!(cols === 4'b1110 || cols === 4'b1101 ||
              cols === 4'b1011 || cols === 4'b0111))
            bad_cols <= bad_cols + 1;
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        down[r*4+c] = 1'b1;
    endtask

    task automatic release_all();
        down = 16'h0;
    endtask

    task automatic wait_state(input state_t s, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dbg_state == s) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int p0;

    initial begin
        // Reset values while held in reset
        tick(3);
        chk("rst_cols", 32'(cols), 32'h0000_000E);
        chk("rst_key", 32'(key), 32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(SCAN));

        // Idle scan: column moves every 4 cycles after reset release
        @(negedge clk);
        reset = 1'b1;
        tick(1);  chk("idle_n1", 32'(cols), 32'hE);
        tick(2);  chk("idle_n3", 32'(cols), 32'hE);
        tick(1);  chk("idle_n4", 32'(cols), 32'hD);
        tick(3);  chk("idle_n7", 32'(cols), 32'hD);
        tick(1);  chk("idle_n8", 32'(cols), 32'hB);
        tick(4);  chk("idle_n12", 32'(cols), 32'h7);
        tick(4);  chk("idle_n16", 32'(cols), 32'hE);
        tick(16); chk("idle_n32", 32'(cols), 32'hE);
        chk("idle_pulses", 32'(pulses), 32'd0);
        chk("idle_key", 32'(key), 32'h0);

        // Press '5' (row1, col1) and hold 40 cycles
        press(1, 1);
        wait_state(DEBOUNCE, 20, "k5_detect");
        chk("k5_detect_cols", 32'(cols), 32'hD);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            chk("k5_hold_cols", 32'(cols), 32'hD);
        end
        chk("k5_pulses", 32'(pulses), 32'd1);
        chk("k5_pulse_key", 32'(pulse_key), 32'h5);
        chk("k5_key", 32'(key), 32'h5);
        chk("k5_state", 32'(dbg_state), 32'(HELD));
        // Release: 2 sync cycles + 1 to enter RELEASE + 8 debounce cycles
        release_all();
        tick(10);
        chk("k5_rel_state", 32'(dbg_state), 32'(RELEASE));
        chk("k5_rel_cols", 32'(cols), 32'hD);
        tick(1);
        chk("k5_done_state", 32'(dbg_state), 32'(SCAN));
        chk("k5_done_cols", 32'(cols), 32'hB);

        // Press '9' (row2, col2) for 3 cycles only: a bounce
        p0 = pulses;
        press(2, 2);
        tick(3);
        release_all();
        tick(1);
        chk("k9_debounce", 32'(dbg_state), 32'(DEBOUNCE));
        wait_state(SCAN, 10, "k9_abandon");
        chk("k9_next_col", 32'(cols), 32'h7);
        tick(4);
        chk("k9_no_pulse", 32'(pulses), 32'(p0));

        // Hold 'A' (row0, col3), glitch, full release, re-press
        press(0, 3);
        wait_state(HELD, 40, "kA_held");
        tick(2);
        chk("kA_pulses", 32'(pulses), 32'(p0 + 1));
        chk("kA_key", 32'(key), 32'hA);
        tick(10);
        release_all();
        tick(4);
        press(0, 3);
        tick(10);
        chk("kA_glitch_state", 32'(dbg_state), 32'(HELD));
        chk("kA_glitch_cols", 32'(cols), 32'h7);
        chk("kA_glitch_pulses", 32'(pulses), 32'(p0 + 1));
        release_all();
        wait_state(SCAN, 20, "kA_released");
        chk("kA_wrap_cols", 32'(cols), 32'hE);
        chk("kA_rel_pulses", 32'(pulses), 32'(p0 + 1));
        press(0, 3);
        wait_state(HELD, 40, "kA_repress");
        tick(2);
        chk("kA_repress_pulses", 32'(pulses), 32'(p0 + 2));
        chk("kA_repress_key", 32'(pulse_key), 32'hA);
        release_all();
        wait_state(SCAN, 30, "kA_final_rel");

        // '1' and '7' together in col0: row0 has priority
        p0 = pulses;
        press(0, 0);
        press(2, 0);
        wait_state(HELD, 40, "k17_held");
        tick(2);
        chk("k17_pulses", 32'(pulses), 32'(p0 + 1));
        chk("k17_key", 32'(key), 32'h1);
        // '3' pressed while '1' held: other columns are not driven
        press(0, 2);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            chk("k3_cols_held", 32'(cols), 32'hE);
        end
        chk("k3_no_pulse", 32'(pulses), 32'(p0 + 1));
        release_all();
        wait_state(SCAN, 30, "k17_rel");

        // Reset mid-DEBOUNCE of 'D' (row3, col3)
        p0 = pulses;
        press(3, 3);
        wait_state(DEBOUNCE, 40, "kD_detect");
        tick(2);
        reset = 1'b0;
        #1;
        chk("kD_rst_cols", 32'(cols), 32'hE);
        chk("kD_rst_key", 32'(key), 32'h0);
        chk("kD_rst_valid", 32'(key_valid), 32'h0);
        chk("kD_rst_state", 32'(dbg_state), 32'(SCAN));
        release_all();
        @(negedge clk);
        reset = 1'b1;
        tick(1);
        chk("kD_after_rst_valid", 32'(key_valid), 32'h0);
        tick(40);
        chk("kD_discarded", 32'(pulses), 32'(p0));
        chk("kD_key_still0", 32'(key), 32'h0);
        press(3, 3);
        wait_state(HELD, 40, "kD_fresh");
        tick(2);
        chk("kD_fresh_pulses", 32'(pulses), 32'(p0 + 1));
        chk("kD_fresh_key", 32'(key), 32'hD);
        release_all();
        wait_state(SCAN, 30, "kD_rel");

        chk("cols_onehot_low", 32'(bad_cols), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
